// File: rtl/ansi_key_decoder.sv
// ansi_key_decoder
// Turns the raw byte stream coming back from the terminal into key events
// (space, enter, quit, cursor arrows, lone ESC, printable characters) for the
// game control logic. ESC-prefixed CSI cursor sequences are parsed, and a lone
// ESC is told apart from the start of a sequence by an inter-byte timeout.
// Events leave through a single-entry valid/ready output register.

module ansi_key_decoder #(
   parameter int ESC_TIMEOUT    = 1000,
   parameter int MAX_CSI_PARAMS = 8,
   parameter int DROP_W         = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [7:0]        in_byte,
   output logic              in_ready,
   output logic              key_valid,
   input  logic              key_ready,
   output logic [3:0]        key_code,
   output logic [7:0]        key_char,
   output logic [DROP_W-1:0] drop_cnt
);

   localparam int TIMER_W = $clog2(ESC_TIMEOUT + 1);
   localparam int PARAM_W = $clog2(MAX_CSI_PARAMS + 1);

   localparam logic [3:0] KEY_SPACE = 4'd0;
   localparam logic [3:0] KEY_ENTER = 4'd1;
   localparam logic [3:0] KEY_QUIT  = 4'd2;
   localparam logic [3:0] KEY_UP    = 4'd3;
   localparam logic [3:0] KEY_DOWN  = 4'd4;
   localparam logic [3:0] KEY_RIGHT = 4'd5;
   localparam logic [3:0] KEY_LEFT  = 4'd6;
   localparam logic [3:0] KEY_ESC   = 4'd7;
   localparam logic [3:0] KEY_CHAR  = 4'd8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ESC,
      ST_CSI
   } state_t;

   state_t              r_state;
   state_t              w_stateNext;
   logic [TIMER_W-1:0]  r_timer;
   logic [PARAM_W-1:0]  r_paramCnt;
   logic                r_keyValid;
   logic [3:0]          r_keyCode;
   logic [7:0]          r_keyChar;
   logic [DROP_W-1:0]   r_dropCnt;

   logic                w_slotFree;
   logic                w_accept;
   logic                w_timerExpired;
   logic                w_isParam;
   logic                w_paramFull;
   logic                w_emit;
   logic [3:0]          w_emitCode;
   logic [7:0]          w_emitChar;
   logic                w_drop;
   logic                w_paramClear;
   logic                w_paramInc;

   // The output register is the only buffer, so a byte may only be taken when
   // the event slot is empty or is being emptied this very cycle. Holding
   // in_ready low while the slot is blocked also keeps bytes from racing a
   // pending timeout ESC.
   assign w_slotFree     = !r_keyValid || key_ready;
   assign in_ready       = w_slotFree;
   assign w_accept       = in_valid && w_slotFree;
   assign w_timerExpired = (r_timer == TIMER_W'(ESC_TIMEOUT));
   assign w_isParam      = (in_byte[7:4] == 4'h3);
   assign w_paramFull    = (r_paramCnt == PARAM_W'(MAX_CSI_PARAMS));

   assign key_valid = r_keyValid;
   assign key_code  = r_keyCode;
   assign key_char  = r_keyChar;
   assign drop_cnt  = r_dropCnt;

   // Parser state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Next parser state: an accepted byte always takes priority over the timer,
   // and a lone-ESC timeout only resolves once it has somewhere to put the ESC.
   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept && (in_byte == 8'h1B)) begin
               w_stateNext = ST_ESC;
            end
         end
         ST_ESC: begin
            if (w_accept) begin
               if (in_byte == 8'h5B) begin
                  w_stateNext = ST_CSI;
               end else if (in_byte != 8'h1B) begin
                  w_stateNext = ST_IDLE;
               end
            end else if (w_timerExpired && w_slotFree) begin
               w_stateNext = ST_IDLE;
            end
         end
         ST_CSI: begin
            if (w_accept) begin
               if (!w_isParam || w_paramFull) begin
                  w_stateNext = ST_IDLE;
               end
            end else if (w_timerExpired) begin
               w_stateNext = ST_IDLE;
            end
         end
         default: w_stateNext = ST_IDLE;
      endcase
   end

   // Decode what this cycle produces: an event to emit, a dropped byte or
   // sequence, and the bookkeeping for CSI parameter bytes.
   always_comb begin
      w_emit       = 1'b0;
      w_emitCode   = KEY_SPACE;
      w_emitChar   = 8'h00;
      w_drop       = 1'b0;
      w_paramClear = 1'b0;
      w_paramInc   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               case (in_byte)
                  8'h20: begin
                     w_emit     = 1'b1;
                     w_emitCode = KEY_SPACE;
                  end
                  8'h0D, 8'h0A: begin
                     w_emit     = 1'b1;
                     w_emitCode = KEY_ENTER;
                  end
                  8'h71, 8'h51: begin
                     w_emit     = 1'b1;
                     w_emitCode = KEY_QUIT;
                  end
                  8'h1B: begin
                     w_emit = 1'b0;
                  end
                  default: begin
                     if ((in_byte >= 8'h21) && (in_byte <= 8'h7E)) begin
                        w_emit     = 1'b1;
                        w_emitCode = KEY_CHAR;
                        w_emitChar = in_byte;
                     end else begin
                        w_drop = 1'b1;
                     end
                  end
               endcase
            end
         end
         ST_ESC: begin
            if (w_accept) begin
               if (in_byte == 8'h5B) begin
                  w_paramClear = 1'b1;
               end else if (in_byte == 8'h1B) begin
                  w_emit     = 1'b1;
                  w_emitCode = KEY_ESC;
               end else begin
                  w_drop = 1'b1;
               end
            end else if (w_timerExpired && w_slotFree) begin
               w_emit     = 1'b1;
               w_emitCode = KEY_ESC;
            end
         end
         ST_CSI: begin
            if (w_accept) begin
               if (w_isParam) begin
                  if (w_paramFull) begin
                     w_drop = 1'b1;
                  end else begin
                     w_paramInc = 1'b1;
                  end
               end else begin
                  case (in_byte)
                     8'h41: begin
                        w_emit     = 1'b1;
                        w_emitCode = KEY_UP;
                     end
                     8'h42: begin
                        w_emit     = 1'b1;
                        w_emitCode = KEY_DOWN;
                     end
                     8'h43: begin
                        w_emit     = 1'b1;
                        w_emitCode = KEY_RIGHT;
                     end
                     8'h44: begin
                        w_emit     = 1'b1;
                        w_emitCode = KEY_LEFT;
                     end
                     default: w_drop = 1'b1;
                  endcase
               end
            end else if (w_timerExpired) begin
               w_drop = 1'b1;
            end
         end
         default: begin
            w_emit = 1'b0;
         end
      endcase
   end

   // Inter-byte timer: restarts on every accepted byte and sits at zero in
   // IDLE; otherwise counts up and parks at ESC_TIMEOUT until resolved.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_timer <= '0;
      end else if (w_accept || (r_state == ST_IDLE) || (w_stateNext == ST_IDLE)) begin
         r_timer <= '0;
      end else if (!w_timerExpired) begin
         r_timer <= r_timer + TIMER_W'(1);
      end
   end

   // Number of CSI parameter bytes seen since the '['.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_paramCnt <= '0;
      end else if (w_paramClear) begin
         r_paramCnt <= '0;
      end else if (w_paramInc) begin
         r_paramCnt <= r_paramCnt + PARAM_W'(1);
      end
   end

   // Single-entry event register: loads on an emit, clears on a handshake,
   // and an emit in the handshake cycle simply replaces the old event.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_keyValid <= 1'b0;
         r_keyCode  <= 4'd0;
         r_keyChar  <= 8'h00;
      end else if (w_emit) begin
         r_keyValid <= 1'b1;
         r_keyCode  <= w_emitCode;
         r_keyChar  <= w_emitChar;
      end else if (r_keyValid && key_ready) begin
         r_keyValid <= 1'b0;
      end
   end

   // Saturating count of bytes and sequences that produced no event.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_dropCnt <= '0;
      end else if (w_drop && (r_dropCnt != {DROP_W{1'b1}})) begin
         r_dropCnt <= r_dropCnt + DROP_W'(1);
      end
   end

endmodule

// File: tb/tb_ansi_key_decoder.sv
// tb_ansi_key_decoder
// Drives directed and random terminal byte streams into ansi_key_decoder.
// A reference model watches which bytes are accepted each cycle, interprets
// them with the key/sequence rules, and queues the expected events; a
// separate monitor pops the queue whenever a new event appears on the output.

module tb_ansi_key_decoder;

   localparam int ESC_TIMEOUT    = 10;
   localparam int MAX_CSI_PARAMS = 8;
   localparam int DROP_W         = 16;

   logic              clk       = 1'b0;
   logic              rst       = 1'b1;
   logic              in_valid  = 1'b0;
   logic [7:0]        in_byte   = 8'h00;
   logic              in_ready;
   logic              key_valid;
   logic              key_ready = 1'b1;
   logic [3:0]        key_code;
   logic [7:0]        key_char;
   logic [DROP_W-1:0] drop_cnt;

   typedef struct {
      logic [3:0] code;
      logic [7:0] chr;
      int         edgeIdx;
   } evt_t;

   evt_t expQ[$];
   int   checks    = 0;
   int   errors    = 0;
   int   readyMode = 0;

   ansi_key_decoder #(
      .ESC_TIMEOUT   (ESC_TIMEOUT),
      .MAX_CSI_PARAMS(MAX_CSI_PARAMS),
      .DROP_W        (DROP_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_byte  (in_byte),
      .in_ready (in_ready),
      .key_valid(key_valid),
      .key_ready(key_ready),
      .key_code (key_code),
      .key_char (key_char),
      .drop_cnt (drop_cnt)
   );

   // Free-running clock, posedges at 5, 15, 25, ...
   always #5 clk = ~clk;

   // Safety net in case something stalls forever.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected finish before 2000000");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0] seq[$];
   int         idleCnt  = 0;
   int         expDrop  = 0;
   bit         primed   = 1'b0;
   int         modelCyc = 0;

   function automatic void pushEvt(input logic [3:0] c, input logic [7:0] ch, input int e);
      evt_t ev;
      ev.code    = c;
      ev.chr     = ch;
      ev.edgeIdx = e;
      expQ.push_back(ev);
   endfunction

   function automatic void dropInc();
      if (expDrop < (1 << DROP_W) - 1) expDrop++;
   endfunction

   // Interprets one accepted byte given the bytes of the sequence so far.
   function automatic void modelByte(input logic [7:0] b, input int e);
      int nParams;
      if (seq.size() == 0) begin
         if (b == 8'h20) pushEvt(4'd0, 8'h00, e);
         else if (b == 8'h0D || b == 8'h0A) pushEvt(4'd1, 8'h00, e);
         else if (b == 8'h71 || b == 8'h51) pushEvt(4'd2, 8'h00, e);
         else if (b >= 8'h21 && b <= 8'h7E) pushEvt(4'd8, b, e);
         else if (b == 8'h1B) begin
            seq.push_back(b);
            idleCnt = 0;
         end else dropInc();
      end else if (seq.size() == 1) begin
         if (b == 8'h5B) begin
            seq.push_back(b);
            idleCnt = 0;
         end else if (b == 8'h1B) begin
            pushEvt(4'd7, 8'h00, e);
            idleCnt = 0;
         end else begin
            dropInc();
            seq.delete();
         end
      end else begin
         nParams = seq.size() - 2;
         if (b >= 8'h30 && b <= 8'h3F) begin
            if (nParams == MAX_CSI_PARAMS) begin
               dropInc();
               seq.delete();
            end else begin
               seq.push_back(b);
               idleCnt = 0;
            end
         end else if (b >= 8'h41 && b <= 8'h44) begin
            pushEvt(4'(3 + int'(b - 8'h41)), 8'h00, e);
            seq.delete();
         end else begin
            dropInc();
            seq.delete();
         end
      end
   endfunction

   // Model process: sampled just before each rising edge, it predicts what
   // that edge does and checks the drop counter and in_ready rule.
   always begin : modelProc
      logic sRst, sAcc, sFree;
      logic [7:0] sByte;
      @(negedge clk);
      #4;
      sRst  = rst;
      sFree = in_ready;
      sAcc  = in_valid && in_ready && !rst;
      sByte = in_byte;
      if (primed && !sRst) begin
         checkOutput("drop_cnt", 32'(drop_cnt), 32'(expDrop));
         checkOutput("in_ready", 32'(in_ready), 32'(!key_valid || key_ready));
      end
      if (sRst) begin
         seq.delete();
         expDrop = 0;
         idleCnt = 0;
         primed  = 1'b1;
      end else if (sAcc) begin
         modelByte(sByte, modelCyc);
      end else if (seq.size() > 0) begin
         idleCnt++;
         if (idleCnt >= ESC_TIMEOUT + 1 && (seq.size() > 1 || sFree)) begin
            if (seq.size() == 1) pushEvt(4'd7, 8'h00, modelCyc);
            else dropInc();
            seq.delete();
            idleCnt = 0;
         end
      end
      modelCyc++;
   end

   // ---------------- monitor ----------------
   int         monCyc = 0;
   logic       pValid = 1'b0;
   logic       pHs    = 1'b0;
   logic       pRst   = 1'b1;
   logic [3:0] pCode  = 4'd0;
   logic [7:0] pChar  = 8'h00;

   // Monitor: pops the scoreboard whenever a fresh event becomes visible and
   // checks that a held event keeps its fields until it is taken.
   always begin : monitorProc
      evt_t e;
      @(negedge clk);
      #4;
      if (key_valid === 1'b1 && (!pValid || pHs || pRst)) begin
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_event: got code %0d char 0x%0h, expected no event", key_code, key_char);
         end else begin
            e = expQ.pop_front();
            checkOutput("event_code", 32'(key_code), 32'(e.code));
            checkOutput("event_char", 32'(key_char), 32'(e.chr));
            checkOutput("event_latency", 32'(monCyc), 32'(e.edgeIdx + 1));
         end
      end else if (key_valid === 1'b1 && pValid && !pHs && !pRst) begin
         checkOutput("event_hold", {20'd0, key_code, key_char}, {20'd0, pCode, pChar});
      end
      pValid = key_valid;
      pHs    = key_valid && key_ready;
      pRst   = rst;
      pCode  = key_code;
      pChar  = key_char;
      monCyc++;
   end

   // Consumer side: always ready, random, or left to the main sequence.
   always @(negedge clk) begin
      if (readyMode == 0) key_ready = 1'b1;
      else if (readyMode == 1) key_ready = 1'($urandom_range(0, 1));
   end

   // ---------------- stimulus ----------------
   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Offers one byte (called at a falling edge) and returns at the falling
   // edge after it was taken.
   task automatic applyStimulus(input logic [7:0] b);
      int waitCnt;
      waitCnt  = 0;
      in_valid = 1'b1;
      in_byte  = b;
      #4;
      while (!in_ready && waitCnt < 200) begin
         @(negedge clk);
         #4;
         waitCnt++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("[TB] FAIL byte_accept: byte 0x%0h not accepted after %0d cycles, expected acceptance", b, waitCnt);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic applyReset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #4;
      checkOutput("reset_key_valid", 32'(key_valid), 32'd0);
      checkOutput("reset_key_code", 32'(key_code), 32'd0);
      checkOutput("reset_key_char", 32'(key_char), 32'd0);
      checkOutput("reset_drop_cnt", 32'(drop_cnt), 32'd0);
      checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
   endtask

   initial begin : mainSeq
      int k;
      int r;
      int nParam;
      @(negedge clk);
      applyReset();

      // Plain keys.
      applyStimulus(8'h20);
      applyStimulus(8'h78);
      applyStimulus(8'h0D);
      applyStimulus(8'h71);
      idle(3);
      #4;
      checkOutput("t1_drop", 32'(drop_cnt), 32'd0);
      @(negedge clk);

      // Cursor sequences, with and without parameters.
      applyStimulus(8'h1B);
      applyStimulus(8'h5B);
      applyStimulus(8'h41);
      applyStimulus(8'h1B);
      applyStimulus(8'h5B);
      applyStimulus(8'h31);
      applyStimulus(8'h3B);
      applyStimulus(8'h35);
      applyStimulus(8'h44);
      idle(3);
      #4;
      checkOutput("t2_drop", 32'(drop_cnt), 32'd0);
      @(negedge clk);

      // Lone ESC resolved by timeout.
      applyStimulus(8'h1B);
      k = 1;
      while (k <= 30) begin
         #4;
         if (key_valid) break;
         @(negedge clk);
         k++;
      end
      checkOutput("t3_esc_latency", 32'(k), 32'd12);
      checkOutput("t3_esc_code", 32'(key_code), 32'd7);
      @(negedge clk);
      applyStimulus(8'h61);
      idle(3);

      // Backpressure from the consumer.
      readyMode = 2;
      @(negedge clk);
      key_ready = 1'b0;
      applyStimulus(8'h61);
      in_valid = 1'b1;
      in_byte  = 8'h62;
      repeat (2) @(negedge clk);
      #4;
      checkOutput("t4_in_ready_blocked", 32'(in_ready), 32'd0);
      checkOutput("t4_held_char", 32'(key_char), 32'h61);
      @(negedge clk);
      key_ready = 1'b1;
      @(negedge clk);
      key_ready = 1'b0;
      in_valid  = 1'b0;
      #4;
      checkOutput("t4_second_valid", 32'(key_valid), 32'd1);
      checkOutput("t4_second_char", 32'(key_char), 32'h62);
      @(negedge clk);
      readyMode = 0;
      key_ready = 1'b1;
      idle(3);

      // Drops: too many CSI parameters, Alt+key, control byte.
      applyReset();
      applyStimulus(8'h1B);
      applyStimulus(8'h5B);
      repeat (9) applyStimulus(8'h31);
      idle(3);
      #4;
      checkOutput("t5_drop_params", 32'(drop_cnt), 32'd1);
      @(negedge clk);
      applyStimulus(8'h1B);
      applyStimulus(8'h78);
      idle(2);
      #4;
      checkOutput("t5_drop_alt", 32'(drop_cnt), 32'd2);
      @(negedge clk);
      applyStimulus(8'h07);
      idle(2);
      #4;
      checkOutput("t5_drop_ctrl", 32'(drop_cnt), 32'd3);
      @(negedge clk);

      // Reset in the middle of a sequence.
      applyReset();
      applyStimulus(8'h1B);
      applyStimulus(8'h5B);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(8'h41);
      #4;
      checkOutput("t6_code", 32'(key_code), 32'd8);
      checkOutput("t6_char", 32'(key_char), 32'h41);
      @(negedge clk);
      idle(2);
      #4;
      checkOutput("t6_drop", 32'(drop_cnt), 32'd0);
      @(negedge clk);

      // Random traffic with a randomly stalling consumer.
      readyMode = 1;
      for (int i = 0; i < 300; i++) begin
         r = $urandom_range(0, 9);
         case (r)
            0, 1, 2, 3: applyStimulus(8'($urandom_range(8'h21, 8'h7E)));
            4: begin
               applyStimulus(8'h1B);
               applyStimulus(8'h5B);
               nParam = $urandom_range(0, 10);
               for (int j = 0; j < nParam; j++) applyStimulus(8'($urandom_range(8'h30, 8'h3F)));
               if ($urandom_range(0, 3) == 0) applyStimulus(8'($urandom_range(0, 255)));
               else applyStimulus(8'($urandom_range(8'h41, 8'h44)));
            end
            5: applyStimulus(8'($urandom_range(0, 255)));
            6: begin
               applyStimulus(8'h1B);
               applyStimulus(8'($urandom_range(0, 255)));
            end
            7: idle($urandom_range(0, 14));
            8: begin
               case ($urandom_range(0, 3))
                  0: applyStimulus(8'h20);
                  1: applyStimulus(8'h0D);
                  2: applyStimulus(8'h0A);
                  default: applyStimulus(8'h51);
               endcase
            end
            default: begin
               applyStimulus(8'h1B);
               idle($urandom_range(8, 16));
            end
         endcase
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end

      readyMode = 0;
      idle(30);
      checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ansi_key_decoder.md
Name: ansi_key_decoder

Overview:
- Input-side counterpart to the ANSI terminal writer: parses the raw byte stream the terminal sends back (stdin bytes fed by the bench/host shim) into discrete key events for the game control logic.
- Recognises plain keys, CR/LF, and ESC-prefixed CSI cursor sequences (ESC [ A..D).
- Resolves a lone ESC by inter-byte timeout.
- Sits between the stdin byte source and control; one event out per recognised key, with a valid/ready handshake.

Parameters:
ESC_TIMEOUT, 1000, cycles without an accepted byte after ESC (or inside CSI) before the sequence is resolved
MAX_CSI_PARAMS, 8, max parameter bytes (0x30-0x3F) tolerated inside a CSI before abort
DROP_W, 16, width of drop counter

Ports:
clk  input  1  system clock (frame/engine clock domain)
rst  input  1  synchronous active-high reset
in_valid  input  1  in_byte holds a terminal byte
in_byte  input  8  raw byte from terminal
in_ready  output  1  decoder can accept a byte; combinational = !key_valid || key_ready
key_valid  output  1  key event pending
key_ready  input  1  consumer accepts event
key_code  output  4  0 SPACE, 1 ENTER, 2 QUIT, 3 UP, 4 DOWN, 5 RIGHT, 6 LEFT, 7 ESC, 8 CHAR
key_char  output  8  raw byte when key_code==CHAR, else 0
drop_cnt  output  DROP_W  saturating count of discarded bytes/sequences

Behaviour:
- One clock (clk); reset is synchronous, active-high (rst). Everything below happens on posedge clk.
- Reset values:
  - FSM state IDLE.
  - key_valid 0, key_code 0, key_char 0.
  - drop_cnt 0, timer 0, param count 0.
  - in_ready therefore 1.
- Byte accepted iff in_valid && in_ready.
- Event handshake:
  - Event emitted = key_valid, key_code and key_char registered on the accepting edge; visible the next cycle (latency 1).
  - key_valid holds, with fields stable, until key_valid && key_ready.
  - An emit and a handshake in the same cycle is allowed (back-to-back events at 1/cycle).
- FSM states: IDLE, ESC, CSI.
- IDLE, on accepted byte:
  - 0x20: emit SPACE.
  - 0x0D or 0x0A: emit ENTER.
  - 'q' or 'Q': emit QUIT.
  - Other 0x21-0x7E: emit CHAR with key_char = byte.
  - 0x1B: go to ESC, timer = 0.
  - Any other byte: drop, drop_cnt+1.
- ESC:
  - Timer increments each cycle with no accepted byte.
  - '[': go to CSI, timer = 0, param count = 0.
  - 0x1B: emit ESC; stay in ESC with timer = 0.
  - Any other byte (Alt+key): discard ESC and byte together, drop_cnt+1, go to IDLE.
  - Timer reaching ESC_TIMEOUT: emit ESC, go to IDLE.
- CSI:
  - 0x30-0x3F: consume (parameters are ignored), param count+1, timer = 0.
  - A parameter byte arriving when param count == MAX_CSI_PARAMS: abort, drop_cnt+1, go to IDLE.
  - Final byte 'A'/'B'/'C'/'D': emit UP/DOWN/RIGHT/LEFT, go to IDLE. Parameters are ignored, so "ESC [1;5A" yields UP.
  - Other final byte 0x40-0x7E, or any byte outside 0x30-0x7E: drop_cnt+1, go to IDLE.
  - Timer reaching ESC_TIMEOUT: abort silently to IDLE, drop_cnt+1.
- Simultaneous events:
  - A byte accepted in the same cycle the timer would expire wins; the timer is ignored that cycle.
  - The timeout ESC emit needs the output slot (!key_valid || key_ready). While it is blocked, the timer saturates at ESC_TIMEOUT and the emit fires on the first free cycle.
  - While blocked, in_ready = 0, so no byte can race the timeout.
- Timer width: clog2(ESC_TIMEOUT+1), saturating; it never wraps.
- drop_cnt saturates at all-ones and never wraps.
- rst asserted mid-sequence or with key_valid high: the pending event and the partial sequence are discarded; all registers return to reset values the next cycle.

Test Plan:
1. Reset, then bytes 0x20, 'x', 0x0D, 'q' with key_ready=1 → key_code sequence 0, 8 (key_char 0x78), 1, 2, each one cycle after acceptance; drop_cnt 0.
2. 0x1B,'[','A' then 0x1B,'[','1',';','5','D' → UP (3) then LEFT (6); no drops.
3. Lone 0x1B then idle, ESC_TIMEOUT=10 → key_code 7 asserted exactly 11 cycles after the ESC accept edge; state back to IDLE, next 'a' → CHAR 0x61.
4. key_ready=0, send 'a','b' → only 'a' held, in_ready=0 and 'b' not accepted; raise key_ready one cycle → 'a' accepted, 'b' accepted next, CHAR 0x62 follows.
5. 0x1B,'[' + 9 bytes '1' (MAX_CSI_PARAMS=8) → no event, drop_cnt=1; 0x1B,'x' → drop_cnt=2; 0x07 → drop_cnt=3.
6. rst pulse after 0x1B,'[' mid-sequence, then 'A' → CHAR 0x41 (not UP), drop_cnt 0.
